// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache onto one word-granular memory port.
// The grant is held while the owner keeps requesting or has reads outstanding.
module cache_mem_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ic_addr,
  input  logic        i_ic_ren,
  output logic        o_ic_ready,
  output logic [31:0] o_ic_rdata,
  output logic        o_ic_valid,
  input  logic [31:0] i_dc_addr,
  input  logic        i_dc_ren,
  input  logic        i_dc_wen,
  input  logic [31:0] i_dc_wdata,
  output logic        o_dc_ready,
  output logic [31:0] o_dc_rdata,
  output logic        o_dc_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_err
);
  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
  } mem_req_t;

  state_t        state, state_nxt;
  logic          last_i, last_i_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err;
  mem_req_t      own;
  logic          gi, gd, req_i, req_d, rsp, stall, acc, mem_ok;

  assign gi    = (state == GNT_I) & ~i_rst;
  assign gd    = (state == GNT_D) & ~i_rst;
  assign req_i = i_ic_ren;
  assign req_d = i_dc_ren | i_dc_wen;
  // A valid with nothing outstanding is spurious and never reaches a cache.
  assign rsp   = i_mem_valid & (cnt != '0);
  assign stall = (cnt == MAX_C) & ~i_mem_valid;

  always_comb begin
    own = '0;
    if (gi) begin
      own.addr = i_ic_addr;
      own.ren  = i_ic_ren;
    end else if (gd) begin
      own.addr  = i_dc_addr;
      own.ren   = i_dc_ren & ~i_dc_wen;
      own.wen   = i_dc_wen;
      own.wdata = i_dc_wdata;
    end
  end

  assign o_mem_addr  = own.addr;
  assign o_mem_ren   = own.ren & ~stall;
  assign o_mem_wen   = own.wen;
  assign o_mem_wdata = own.wdata;

  // Writes are uncounted, so they keep flowing while reads are throttled.
  assign mem_ok     = i_mem_ready & (~stall | own.wen);
  assign o_ic_ready = gi & mem_ok;
  assign o_dc_ready = gd & mem_ok;
  assign o_ic_valid = gi & rsp;
  assign o_dc_valid = gd & rsp;
  assign o_ic_rdata = o_ic_valid ? i_mem_rdata : '0;
  assign o_dc_rdata = o_dc_valid ? i_mem_rdata : '0;
  assign o_err      = err & ~i_rst;

  assign acc     = o_mem_ren & i_mem_ready;
  assign cnt_nxt = cnt + CW'(acc) - CW'(rsp);

  always_comb begin
    state_nxt  = state;
    last_i_nxt = last_i;
    case (state)
      IDLE: begin
        if (req_i & (~req_d | ~last_i)) begin
          state_nxt  = GNT_I;
          last_i_nxt = 1'b1;
        end else if (req_d) begin
          state_nxt  = GNT_D;
          last_i_nxt = 1'b0;
        end
      end
      GNT_I:   if (~req_i & (cnt_nxt == '0)) state_nxt = IDLE;
      GNT_D:   if (~req_d & (cnt_nxt == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      last_i <= 1'b1;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_i <= last_i_nxt;
      cnt    <= cnt_nxt;
      err    <= err | (i_mem_valid & (cnt == '0)) | (i_dc_ren & i_dc_wen);
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: caches are driven step by step, memory is an in-order
// model returning addr ^ 0xA5A50000 after a programmable number of cycles.
module tb_cache_mem_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0;
  logic        ic_ren = 1'b0, dc_ren = 1'b0, dc_wen = 1'b0;
  logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid;
  logic [31:0] o_ic_rdata, o_dc_rdata, o_mem_addr, o_mem_wdata;
  logic        o_mem_ren, o_mem_wen, o_err;
  logic        mem_ready = 1'b1;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;

  cache_mem_arbiter #(.MAX_OUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ic_addr(ic_addr), .i_ic_ren(ic_ren), .o_ic_ready(o_ic_ready),
    .o_ic_rdata(o_ic_rdata), .o_ic_valid(o_ic_valid),
    .i_dc_addr(dc_addr), .i_dc_ren(dc_ren), .i_dc_wen(dc_wen), .i_dc_wdata(dc_wdata),
    .o_dc_ready(o_dc_ready), .o_dc_rdata(o_dc_rdata), .o_dc_valid(o_dc_valid),
    .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .i_mem_ready(mem_ready), .i_mem_rdata(i_mem_rdata),
    .i_mem_valid(i_mem_valid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int due; logic [31:0] addr;} pend_t;
  pend_t       q[$];
  int          cyc = 0, lat = 1, out_cnt = 0, max_out = 0, wr_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0, mrd = '0;
  logic        mv = 1'b0, spur = 1'b0;
  logic [31:0] ic_q[$], dc_q[$];
  int          ic_left = 0, dc_left = 0, nchk = 0, nfail = 0;

  assign i_mem_valid = mv | spur;
  assign i_mem_rdata = mv ? mrd : 32'h0;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (i_rst) begin
      q.delete();
      mv      <= 1'b0;
      out_cnt <= 0;
    end else begin
      if (o_mem_ren && mem_ready) q.push_back('{due: cyc + lat - 1, addr: o_mem_addr});
      out_cnt <= out_cnt + ((o_mem_ren && mem_ready) ? 1 : 0) - (mv ? 1 : 0);
      if (o_mem_wen && mem_ready) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= o_mem_addr;
        wr_data <= o_mem_wdata;
      end
      mv <= 1'b0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        mrd <= q[0].addr ^ 32'hA5A50000;
        mv  <= 1'b1;
        void'(q.pop_front());
      end
    end
  end

  always @(posedge i_clk) if (out_cnt > max_out) max_out <= out_cnt;

  always @(posedge i_clk) begin
    if (!i_rst && o_ic_valid) ic_q.push_back(o_ic_rdata);
    if (!i_rst && o_dc_valid) dc_q.push_back(o_dc_rdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change only at negedge so the memory model never races them.
  task automatic tick();
    logic ia, da;
    ia = ic_ren & o_ic_ready;
    da = (dc_ren | dc_wen) & o_dc_ready;
    @(posedge i_clk);
    @(negedge i_clk);
    if (ia) begin
      ic_addr += 4; ic_left--;
      if (ic_left == 0) ic_ren = 1'b0;
    end
    if (da) begin
      dc_addr += 4; dc_left--;
      if (dc_left == 0) begin dc_ren = 1'b0; dc_wen = 1'b0; end
    end
    #1;
  endtask

  task automatic req_ic(input logic [31:0] a, input int n);
    ic_addr = a; ic_left = n; ic_ren = 1'b1; #1;
  endtask

  task automatic req_dc(input logic [31:0] a, input int n);
    dc_addr = a; dc_left = n; dc_ren = 1'b1; #1;
  endtask

  task automatic drain(input int ni, input int nd);
    int k = 0;
    while ((ic_q.size() < ni || dc_q.size() < nd) && k < 200) begin
      tick(); k++;
    end
    chk("drain_ic", ic_q.size(), ni);
    chk("drain_dc", dc_q.size(), nd);
  endtask

  initial begin
    int hold_bad;
    @(negedge i_clk); #1;
    tick(); tick();
    chk("rst_ren", o_mem_ren, 0);
    chk("rst_ic_rdy", o_ic_ready, 0);
    chk("rst_dc_rdy", o_dc_ready, 0);
    chk("rst_err", o_err, 0);
    i_rst = 1'b0; #1;

    // icache alone, four words
    req_ic(32'h100, 4);
    chk("a_arb_lat", o_ic_ready, 0);
    tick();
    chk("a_grant", o_ic_ready, 1);
    chk("a_addr", o_mem_addr, 32'h100);
    chk("a_ren", o_mem_ren, 1);
    drain(4, 0);
    chk("a_d0", ic_q[0], 32'hA5A50100);
    chk("a_d1", ic_q[1], 32'hA5A50104);
    chk("a_d2", ic_q[2], 32'hA5A50108);
    chk("a_d3", ic_q[3], 32'hA5A5010C);
    chk("a_idle", o_mem_addr, 32'h0);
    ic_q.delete(); dc_q.delete();

    // tie straight out of reset: dcache first, then alternation
    i_rst = 1'b1; tick(); i_rst = 1'b0; #1;
    req_ic(32'h300, 2);
    req_dc(32'h400, 2);
    tick();
    chk("b_dc_first", o_dc_ready, 1);
    chk("b_ic_wait", o_ic_ready, 0);
    chk("b_addr", o_mem_addr, 32'h400);
    drain(2, 2);
    chk("b_dc0", dc_q[0], 32'hA5A50400);
    chk("b_dc1", dc_q[1], 32'hA5A50404);
    chk("b_ic0", ic_q[0], 32'hA5A50300);
    chk("b_ic1", ic_q[1], 32'hA5A50304);
    ic_q.delete(); dc_q.delete();
    req_ic(32'h500, 1);
    req_dc(32'h600, 1);
    tick();
    chk("b_tie2_dc", o_dc_ready, 1);
    chk("b_tie2_ic", o_ic_ready, 0);
    drain(1, 1);
    ic_q.delete(); dc_q.delete();

    // dcache write while icache waits
    req_ic(32'h700, 1);
    dc_addr = 32'h200; dc_wdata = 32'hDEADBEEF; dc_left = 1; dc_wen = 1'b1; #1;
    tick();
    chk("c_wen", o_mem_wen, 1);
    chk("c_addr", o_mem_addr, 32'h200);
    chk("c_wdata", o_mem_wdata, 32'hDEADBEEF);
    chk("c_ren", o_mem_ren, 0);
    chk("c_ic_wait", o_ic_ready, 0);
    tick();
    chk("c_one_wen", o_mem_wen, 0);
    chk("c_rel_hold", o_mem_addr, 32'h204);
    tick();
    chk("c_idle", o_mem_addr, 32'h0);
    tick();
    chk("c_ic_gnt", o_ic_ready, 1);
    chk("c_ic_addr", o_mem_addr, 32'h700);
    chk("c_wr_cnt", wr_cnt, 1);
    chk("c_wr_addr", wr_addr, 32'h200);
    chk("c_wr_data", wr_data, 32'hDEADBEEF);
    drain(1, 0);
    ic_q.delete();

    // first data 5 cycles after accept so the 5th read reaches the limit
    lat = 5;
    req_ic(32'h800, 5);
    tick();
    chk("d_g1_ren", o_mem_ren, 1);
    tick(); tick(); tick();
    chk("d_g4_ren", o_mem_ren, 1);
    tick();
    chk("d_stall_ren", o_mem_ren, 0);
    chk("d_stall_rdy", o_ic_ready, 0);
    tick();
    chk("d_valid", o_ic_valid, 1);
    chk("d_resume", o_mem_ren, 1);
    hold_bad = 0;
    for (int k = 0; k < 100 && ic_q.size() < 5; k++) begin
      tick();
      if (ic_left == 0 && ic_q.size() < 5 && o_mem_addr !== 32'h814) hold_bad++;
    end
    chk("d_count", ic_q.size(), 5);
    chk("d_hold", hold_bad, 0);
    chk("d_d0", ic_q[0], 32'hA5A50800);
    chk("d_d4", ic_q[4], 32'hA5A50810);
    chk("d_max_out", max_out, 4);
    chk("d_idle", o_mem_addr, 32'h0);
    ic_q.delete();
    lat = 1;

    // spurious valid in IDLE
    chk("e_err_pre", o_err, 0);
    spur = 1'b1; #1;
    chk("e_icv", o_ic_valid, 0);
    chk("e_dcv", o_dc_valid, 0);
    tick();
    spur = 1'b0; #1;
    chk("e_err", o_err, 1);
    tick(); tick(); tick();
    chk("e_sticky", o_err, 1);

    // reset mid-burst with memory quiet
    lat = 30;
    req_ic(32'h900, 8);
    tick(); tick();
    chk("f_pre_ren", o_mem_ren, 1);
    i_rst = 1'b1; ic_ren = 1'b0; ic_left = 0; #1;
    chk("f_rst_ren", o_mem_ren, 0);
    chk("f_rst_addr", o_mem_addr, 32'h0);
    chk("f_rst_err", o_err, 0);
    tick();
    i_rst = 1'b0; lat = 1; #1;
    chk("f_idle_addr", o_mem_addr, 32'h0);
    chk("f_err_clr", o_err, 0);
    req_ic(32'hA00, 1);
    chk("f_arb_lat", o_ic_ready, 0);
    tick();
    chk("f_gnt", o_ic_ready, 1);
    chk("f_addr", o_mem_addr, 32'hA00);
    drain(1, 0);
    chk("f_data", ic_q[0], 32'hA5A50A00);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
